muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and result bundle between the pipeline (master) and the HI/LO multiply/divide unit (slave).
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cancel;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B, Cancel,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, Cancel,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers and a
// fixed-latency busy window; results are computed from latched operands at commit.
module muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     Clk,
  input  logic     Reset,
  muldiv_if.slave  bus
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             is_signed_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_div;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               div_by_zero;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Signed division via magnitudes: MIN/-1 falls out as quotient MIN, remainder 0.
  always_comb begin
    a_ext       = {{WIDTH{is_signed_q & a_q[WIDTH-1]}}, a_q};
    b_ext       = {{WIDTH{is_signed_q & b_q[WIDTH-1]}}, b_q};
    prod        = a_ext * b_ext;
    a_neg       = is_signed_q & a_q[WIDTH-1];
    b_neg       = is_signed_q & b_q[WIDTH-1];
    a_mag       = a_neg ? -a_q : a_q;
    b_mag       = b_neg ? -b_q : b_q;
    div_by_zero = (b_q == '0);
    b_div       = div_by_zero ? WIDTH'(1) : b_mag;
    q_mag       = a_mag / b_div;
    r_mag       = a_mag % b_div;
    quo         = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem         = a_neg ? -r_mag : r_mag;
    res_hi      = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo      = is_div_q ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.Start && !bus.Cancel) begin
            case (bus.Op)
              OP_MULT, OP_MULTU: begin
                a_q         <= bus.A;
                b_q         <= bus.B;
                is_div_q    <= 1'b0;
                is_signed_q <= (bus.Op == OP_MULT);
                cnt_q       <= MULT_LOAD;
                state_q     <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                a_q         <= bus.A;
                b_q         <= bus.B;
                is_div_q    <= 1'b1;
                is_signed_q <= (bus.Op == OP_DIV);
                cnt_q       <= DIV_LOAD;
                state_q     <= S_RUN;
              end
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // Cancel wins over a commit landing on the same edge.
          if (bus.Cancel) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            if (!(is_div_q && div_by_zero)) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy = (state_q == S_RUN);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: default-latency instance plus a 1-cycle instance for back-to-back ops.
module tb_muldiv_unit;

  logic Clk;
  logic Reset;
  int unsigned n_tests;
  int unsigned n_fail;

  muldiv_if #(.WIDTH(32)) bus  ();
  muldiv_if #(.WIDTH(32)) bus1 ();

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_fast (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Launch an op on the default instance and check the busy window and Done pulse.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned n_exp, input string tag);
    int unsigned busy_n;
    int unsigned bad;
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = bus.HI;
    lo0 = bus.LO;
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    tick();
    bus.Start = 1'b0;
    busy_n = 0;
    bad    = 0;
    while (bus.Busy && busy_n < 200) begin
      busy_n++;
      if (bus.HI !== hi0 || bus.LO !== lo0 || bus.Done !== 1'b0) bad++;
      tick();
    end
    chk({tag, "_busy"},  64'(busy_n), 64'(n_exp));
    chk({tag, "_hold"},  64'(bad), 64'd0);
    chk({tag, "_done"},  64'(bus.Done), 64'd1);
    tick();
    chk({tag, "_done1"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.Start = 1'b0;  bus.Op = 3'd0;  bus.A = '0;  bus.B = '0;  bus.Cancel = 1'b0;
    bus1.Start = 1'b0; bus1.Op = 3'd0; bus1.A = '0; bus1.B = '0; bus1.Cancel = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_hi",   64'(bus.HI), 64'd0);
    chk("rst_lo",   64'(bus.LO), 64'd0);
    Reset = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, "mult");
    chk("mult_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.LO), 64'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, "div");
    chk("div_lo", 64'(bus.LO), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus.HI), 64'hFFFF_FFFF);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, "divu");
    chk("divu_lo", 64'(bus.LO), 64'h7FFF_FFFC);
    chk("divu_hi", 64'(bus.HI), 64'h0000_0001);

    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 10, "divpn");
    chk("divpn_lo", 64'(bus.LO), 64'hFFFF_FFFD);
    chk("divpn_hi", 64'(bus.HI), 64'h0000_0001);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, "ovf");
    chk("ovf_lo", 64'(bus.LO), 64'h8000_0000);
    chk("ovf_hi", 64'(bus.HI), 64'h0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu");
    chk("multu_hi", 64'(bus.HI), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(bus.LO), 64'h0000_0001);

    bus.Start = 1'b1; bus.Op = 3'd4; bus.A = 32'h11;
    tick();
    chk("mthi_hi",   64'(bus.HI), 64'h11);
    chk("mthi_busy", 64'(bus.Busy), 64'd0);
    bus.Op = 3'd5; bus.A = 32'h22;
    tick();
    bus.Start = 1'b0;
    chk("mtlo_lo",   64'(bus.LO), 64'h22);
    chk("mtlo_done", 64'(bus.Done), 64'd0);

    run_op(3'd3, 32'd5, 32'd0, 10, "dz");
    chk("dz_hi", 64'(bus.HI), 64'h11);
    chk("dz_lo", 64'(bus.LO), 64'h22);

    // Cancel during the third busy cycle.
    bus.Start = 1'b1; bus.Op = 3'd1; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    chk("cxl_busy", 64'(bus.Busy), 64'd0);
    chk("cxl_done", 64'(bus.Done), 64'd0);
    tick();
    chk("cxl_done1", 64'(bus.Done), 64'd0);
    chk("cxl_hi",    64'(bus.HI), 64'h11);
    chk("cxl_lo",    64'(bus.LO), 64'h22);

    bus.Start = 1'b1; bus.Op = 3'd1; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rmid_busy", 64'(bus.Busy), 64'd0);
    chk("rmid_hi",   64'(bus.HI), 64'h0);
    chk("rmid_lo",   64'(bus.LO), 64'h0);
    tick();
    chk("rmid_done", 64'(bus.Done), 64'd0);

    bus.Start = 1'b1; bus.Op = 3'd4; bus.A = 32'h55; bus.Cancel = 1'b1;
    tick();
    chk("cidle_hi", 64'(bus.HI), 64'h0);
    bus.Op = 3'd0; bus.A = 32'd2; bus.B = 32'd3;
    tick();
    chk("cidle_busy", 64'(bus.Busy), 64'd0);
    bus.Cancel = 1'b0;
    bus.Op = 3'd6; bus.A = 32'h99;
    tick();
    bus.Op = 3'd7;
    tick();
    bus.Start = 1'b0;
    chk("nop_busy", 64'(bus.Busy), 64'd0);
    chk("nop_hi",   64'(bus.HI), 64'h0);
    chk("nop_lo",   64'(bus.LO), 64'h0);

    // MTLO issued mid-multiply must be dropped.
    begin
      int unsigned busy_n;
      bus.Start = 1'b1; bus.Op = 3'd0; bus.A = 32'h10; bus.B = 32'h3;
      tick();
      busy_n = 1;
      bus.Op = 3'd5; bus.A = 32'h1234;
      tick();
      bus.Start = 1'b0;
      while (bus.Busy && busy_n < 200) begin
        busy_n++;
        tick();
      end
      chk("mtlo_busy_n", 64'(busy_n), 64'd5);
      chk("mtlo_busy_lo", 64'(bus.LO), 64'h30);
      chk("mtlo_busy_hi", 64'(bus.HI), 64'h0);
      chk("mtlo_busy_done", 64'(bus.Done), 64'd1);
    end
    bus.Start = 1'b1; bus.Op = 3'd5; bus.A = 32'h1234;
    tick();
    bus.Start = 1'b0;
    chk("mtlo_idle_lo",   64'(bus.LO), 64'h1234);
    chk("mtlo_idle_busy", 64'(bus.Busy), 64'd0);
    chk("mtlo_idle_done", 64'(bus.Done), 64'd0);

    // Cancel landing exactly on the commit edge.
    bus.Start = 1'b1; bus.Op = 3'd0; bus.A = 32'd2; bus.B = 32'd3;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("cc_busy_pre", 64'(bus.Busy), 64'd1);
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    chk("cc_busy", 64'(bus.Busy), 64'd0);
    chk("cc_done", 64'(bus.Done), 64'd0);
    chk("cc_lo",   64'(bus.LO), 64'h1234);

    Reset = 1'b1;
    bus.Start = 1'b1; bus.Op = 3'd4; bus.A = 32'h77;
    tick();
    Reset = 1'b0;
    bus.Start = 1'b0;
    chk("rprio_hi", 64'(bus.HI), 64'h0);
    chk("rprio_lo", 64'(bus.LO), 64'h0);

    // One-cycle latency instance: MULT then DIV with no gap.
    bus1.Start = 1'b1; bus1.Op = 3'd0; bus1.A = 32'd6; bus1.B = 32'd7;
    tick();
    bus1.Start = 1'b0;
    chk("f_mul_busy", 64'(bus1.Busy), 64'd1);
    chk("f_mul_done0", 64'(bus1.Done), 64'd0);
    bus1.Start = 1'b1; bus1.Op = 3'd2; bus1.A = 32'd100; bus1.B = 32'd7;
    tick();
    chk("f_mul_busy1", 64'(bus1.Busy), 64'd0);
    chk("f_mul_done", 64'(bus1.Done), 64'd1);
    chk("f_mul_lo",   64'(bus1.LO), 64'd42);
    chk("f_mul_hi",   64'(bus1.HI), 64'd0);
    tick();
    bus1.Start = 1'b0;
    chk("f_div_busy",  64'(bus1.Busy), 64'd1);
    chk("f_div_done0", 64'(bus1.Done), 64'd0);
    tick();
    chk("f_div_busy1", 64'(bus1.Busy), 64'd0);
    chk("f_div_done",  64'(bus1.Done), 64'd1);
    chk("f_div_lo",    64'(bus1.LO), 64'd14);
    chk("f_div_hi",    64'(bus1.HI), 64'd2);
    tick();
    chk("f_div_done1", 64'(bus1.Done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
